// File: rtl/llt_2_pkg.sv
// rtl/llt_2_pkg.sv - shared Q16.16 constants, FSM encoding and saturating add helper
package llt_2_pkg;

    localparam int Q_WIDTH = 32;
    localparam int Q_FRAC  = 16;

    localparam logic [Q_WIDTH-1:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [Q_WIDTH-1:0] SAT_NEG = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M11  = 3'd1,
        M21  = 3'd2,
        M2A  = 3'd3,
        M2B  = 3'd4,
        DONE = 3'd5
    } state_t;

    // 33-bit signed add of two Q16.16 terms, clamped to the 32-bit range
    function automatic logic [Q_WIDTH-1:0] sat_add(input logic [Q_WIDTH-1:0] a,
                                                   input logic [Q_WIDTH-1:0] b);
        logic [Q_WIDTH:0] sum;
        sum = {a[Q_WIDTH-1], a} + {b[Q_WIDTH-1], b};
        if (sum[Q_WIDTH] != sum[Q_WIDTH-1]) begin
            sat_add = sum[Q_WIDTH] ? SAT_NEG : SAT_POS;
        end else begin
            sat_add = sum[Q_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/llt_2_q16_mul_sat.sv
// rtl/llt_2_q16_mul_sat.sv - combinational Q16.16 multiply with floor truncation and saturation
module q16_mul_sat
    import llt_2_pkg::*;
(
    input  logic [Q_WIDTH-1:0] a,
    input  logic [Q_WIDTH-1:0] b,
    output logic [Q_WIDTH-1:0] y
);

    logic signed [2*Q_WIDTH-1:0] a_ext;
    logic signed [2*Q_WIDTH-1:0] b_ext;
    logic signed [2*Q_WIDTH-1:0] prod;
    logic signed [2*Q_WIDTH-Q_FRAC-1:0] prod_hi;
    logic fits;

    assign a_ext = {{Q_WIDTH{a[Q_WIDTH-1]}}, a};
    assign b_ext = {{Q_WIDTH{b[Q_WIDTH-1]}}, b};
    assign prod  = a_ext * b_ext;

    // Arithmetic shift drops the fraction LSBs, i.e. truncation toward minus infinity
    assign prod_hi = (2*Q_WIDTH-Q_FRAC)'(prod >>> Q_FRAC);

    // Result fits when every bit above the kept sign bit matches it (prod[63:47])
    assign fits = (&prod_hi[2*Q_WIDTH-Q_FRAC-1:Q_WIDTH-1]) |
                  ~(|prod_hi[2*Q_WIDTH-Q_FRAC-1:Q_WIDTH-1]);

    // Clamp to the signed 32-bit range when the product does not fit
    always_comb begin
        y = prod_hi[Q_WIDTH-1:0];
        if (!fits) begin
            y = prod_hi[2*Q_WIDTH-Q_FRAC-1] ? SAT_NEG : SAT_POS;
        end
    end

endmodule

// File: rtl/llt_2.sv
// rtl/llt_2.sv - 2x2 L*L^T product using one time-multiplexed Q16.16 multiplier
module llt_2
    import llt_2_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [95:0] L,
    input  logic        L_valid,
    output logic        L_ready,
    output logic [95:0] P,
    output logic        P_valid
);

    state_t state;
    state_t state_nxt;

    logic [95:0]        l_q;
    logic [Q_WIDTH-1:0] l11;
    logic [Q_WIDTH-1:0] l21;
    logic [Q_WIDTH-1:0] l22;

    logic [Q_WIDTH-1:0] mul_a;
    logic [Q_WIDTH-1:0] mul_b;
    logic [Q_WIDTH-1:0] mul_y;

    logic [Q_WIDTH-1:0] p11_q;
    logic [Q_WIDTH-1:0] p21_q;
    logic [Q_WIDTH-1:0] p2a_q;
    logic [Q_WIDTH-1:0] p22_q;

    assign l11 = l_q[31:0];
    assign l21 = l_q[63:32];
    assign l22 = l_q[95:64];

    q16_mul_sat u_mul (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    // State register; reset wins over clk_en and over an offered L
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    // Next state, handshake and multiplier operand selection
    always_comb begin
        state_nxt = state;
        mul_a     = '0;
        mul_b     = '0;
        L_ready   = 1'b0;
        case (state)
            IDLE: begin
                L_ready = 1'b1;
                if (L_valid) begin
                    state_nxt = M11;
                end
            end
            M11: begin
                mul_a     = l11;
                mul_b     = l11;
                state_nxt = M21;
            end
            M21: begin
                mul_a     = l21;
                mul_b     = l11;
                state_nxt = M2A;
            end
            M2A: begin
                mul_a     = l21;
                mul_b     = l21;
                state_nxt = M2B;
            end
            M2B: begin
                mul_a     = l22;
                mul_b     = l22;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch and partial products, one multiply result captured per state
    always_ff @(posedge clk) begin
        if (rst) begin
            l_q   <= '0;
            p11_q <= '0;
            p21_q <= '0;
            p2a_q <= '0;
            p22_q <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: if (L_valid) l_q <= L;
                M11:  p11_q <= mul_y;
                M21:  p21_q <= mul_y;
                M2A:  p2a_q <= mul_y;
                M2B:  p22_q <= sat_add(p2a_q, mul_y);
                default: ;
            endcase
        end
    end

    // Result register written only on leaving DONE; P_valid is a one-enabled-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            P       <= '0;
            P_valid <= 1'b0;
        end else if (clk_en) begin
            P_valid <= (state == DONE);
            if (state == DONE) begin
                P <= {p22_q, p21_q, p11_q};
            end
        end
    end

endmodule

// File: tb/tb_llt_2.sv
// tb/tb_llt_2.sv - directed table-driven bench for llt_2
module tb_llt_2;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [95:0] L;
    logic        L_valid;
    logic        L_ready;
    logic [95:0] P;
    logic        P_valid;

    int tests;
    int failed;

    typedef struct {
        logic [95:0] l;
        logic [95:0] p;
    } vec_t;

    vec_t vecs[8];

    llt_2 dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .L       (L),
        .L_valid (L_valid),
        .L_ready (L_ready),
        .P       (P),
        .P_valid (P_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one matrix from IDLE, then check latency, result, pulse width and P stability
    task automatic run_vec(input int i);
        logic [95:0] p_before;
        int  edges;
        bit  seen;
        bit  stable;
        p_before = P;
        edges    = 0;
        seen     = 0;
        stable   = 1;
        L       = vecs[i].l;
        L_valid = 1'b1;
        tick();
        L_valid = 1'b0;
        L       = {$urandom, $urandom, $urandom};
        while (!seen && edges < 20) begin
            if (P_valid) begin
                seen = 1;
            end else begin
                if (P !== p_before) stable = 0;
                tick();
                edges++;
            end
        end
        check($sformatf("v%0d_seen", i), 96'(seen), 96'd1);
        check($sformatf("v%0d_latency", i), 96'(edges), 96'd5);
        check($sformatf("v%0d_p", i), P, vecs[i].p);
        check($sformatf("v%0d_p_stable", i), 96'(stable), 96'd1);
        tick();
        check($sformatf("v%0d_pulse_end", i), 96'(P_valid), 96'd0);
        check($sformatf("v%0d_ready", i), 96'(L_ready), 96'd1);
    endtask

    initial begin
        bit          any_pv;
        int          edges;
        logic [95:0] p_hold;

        tests  = 0;
        failed = 0;

        vecs[0] = '{96'h0001_8000_0000_8000_0002_0000, 96'h0002_8000_0001_0000_0004_0000};
        vecs[1] = '{96'h0001_0000_FFFF_8000_0002_0000, 96'h0001_4000_FFFF_0000_0004_0000};
        vecs[2] = '{96'h0100_0000_0000_0000_0100_0000, 96'h7FFF_FFFF_0000_0000_7FFF_FFFF};
        vecs[3] = '{96'h0000_0000_FF00_0000_0100_0000, 96'h7FFF_FFFF_8000_0000_7FFF_FFFF};
        vecs[4] = '{96'h00B5_0000_00B5_0000_0001_0000, 96'h7FFF_FFFF_00B5_0000_0001_0000};
        vecs[5] = '{96'h0003_0000_0000_0001_FFFF_FFFF, 96'h0009_0000_FFFF_FFFF_0000_0000};
        vecs[6] = '{96'h0000_0000_0000_0000_0000_0000, 96'h0000_0000_0000_0000_0000_0000};
        vecs[7] = '{96'h0000_0000_8000_0000_8000_0000, 96'h7FFF_FFFF_7FFF_FFFF_7FFF_FFFF};

        rst     = 1'b1;
        clk_en  = 1'b1;
        L       = '0;
        L_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_ready", 96'(L_ready), 96'd1);
        check("reset_p", P, 96'd0);
        check("reset_pvalid", 96'(P_valid), 96'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end

        // clk_en low for 3 cycles while in M21 stretches latency by 3
        run_vec(1);
        p_hold  = P;
        L       = vecs[0].l;
        L_valid = 1'b1;
        tick();
        L_valid = 1'b0;
        tick();
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("stall_ready", 96'(L_ready), 96'd0);
        check("stall_p_hold", P, p_hold);
        clk_en = 1'b1;
        edges  = 4;
        any_pv = 0;
        while (!P_valid && edges < 30) begin
            tick();
            edges++;
        end
        check("stall_latency", 96'(edges), 96'd8);
        check("stall_p", P, vecs[0].p);
        clk_en = 1'b0;
        tick();
        tick();
        check("stall_pvalid_hold", 96'(P_valid), 96'd1);
        clk_en = 1'b1;
        tick();
        check("stall_pvalid_clear", 96'(P_valid), 96'd0);

        // Reset in M2A, applied with clk_en low, aborts the matrix
        L       = vecs[1].l;
        L_valid = 1'b1;
        tick();
        L_valid = 1'b0;
        tick();
        tick();
        rst    = 1'b1;
        clk_en = 1'b0;
        tick();
        rst    = 1'b0;
        clk_en = 1'b1;
        check("abort_ready", 96'(L_ready), 96'd1);
        check("abort_p", P, 96'd0);
        check("abort_pvalid", 96'(P_valid), 96'd0);
        any_pv = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (P_valid) any_pv = 1;
        end
        check("abort_no_pvalid", 96'(any_pv), 96'd0);

        // Reset beats a simultaneous L_valid
        rst     = 1'b1;
        L       = vecs[0].l;
        L_valid = 1'b1;
        tick();
        rst     = 1'b0;
        L_valid = 1'b0;
        check("rst_prio_ready", 96'(L_ready), 96'd1);
        any_pv = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (P_valid) any_pv = 1;
        end
        check("rst_prio_no_pvalid", 96'(any_pv), 96'd0);

        // L_valid held high for 20 cycles; only every 6th L is taken
        for (int c = 0; c < 20; c++) begin
            check($sformatf("b2b_ready_c%0d", c), 96'(L_ready), 96'((c % 6) == 0));
            check($sformatf("b2b_pvalid_c%0d", c), 96'(P_valid), 96'(((c % 6) == 0) && (c > 0)));
            if (((c % 6) == 0) && (c > 0)) begin
                check($sformatf("b2b_p_c%0d", c), P, vecs[((c / 6) - 1) % 2].p);
            end
            L_valid = 1'b1;
            if ((c % 6) == 0) L = vecs[(c / 6) % 2].l;
            else              L = {$urandom, $urandom, $urandom};
            tick();
        end
        L_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
